svm_ovr_ctrl: RTL and testbench

One-vs-rest linear SVM classification controller sitting behind the IP's AXI-lite register bank and in front of its AXI-full-backed coefficient/feature memory. On a start command it sequences single-port memory reads of the feature vector, per-class weight vectors and per-class biases. It drives an internal signed multiply-accumulate, computes one score per class, and reports the argmax class and its score with a done pulse.

---
 rtl/svm_ovr_ctrl_pkg.sv | 26 ++
 rtl/svm_ovr_ctrl_if.sv | 17 +
 rtl/svm_ovr_ctrl_mac.sv | 38 +++
 rtl/svm_ovr_ctrl.sv | 165 ++++++++++++++++
 tb/tb_svm_ovr_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/svm_ovr_ctrl_pkg.sv
// Shared types and defaults for the one-vs-rest SVM controller.
// Latency: n/a (types, constants and a cycle-count helper only).
// Backpressure: n/a.
package svm_ctrl_pkg;

   localparam int DATA_W_DEF    = 16;
   localparam int ADDR_W_DEF    = 12;
   localparam int ACC_W_DEF     = 48;
   localparam int FRAC_W_DEF    = 8;
   localparam int MAX_CLASS_DEF = 16;

   typedef enum logic [2:0] {
      S_IDLE,
      S_BIAS,
      S_RD_X,
      S_RD_W,
      S_DRAIN,
      S_CMP
   } state_t;

   // Busy cycles of one job: per class BIAS + n_feat*(RD_X+RD_W) + DRAIN + CMP.
   function automatic int job_cycles(input int n_feat, input int n_class);
      return n_class * (2 * n_feat + 3);
   endfunction

endpackage

// File: rtl/svm_ovr_ctrl_if.sv
// Single-port memory read bus between the controller and coefficient memory.
// Latency: rd_data is valid exactly one cycle after rd_en.
// Backpressure: none; every read strobe is served on the following cycle.
// Ports: rd_en/rd_addr from master (controller), rd_data from slave (memory).
interface svm_ovr_ctrl_if
   import svm_ctrl_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
);
   logic                     rd_en;
   logic [ADDR_W-1:0]        rd_addr;
   logic signed [DATA_W-1:0] rd_data;

   modport master (output rd_en, output rd_addr, input rd_data);
   modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/svm_ovr_ctrl_mac.sv
// Signed multiply-accumulate: combinational DATA_W x DATA_W product, registered accumulator.
// Latency: acc updates on the edge where load or acc_en is high.
// Backpressure: none; the controller decides every cycle whether to load or accumulate.
// Ports: load (acc <= din<<<FRAC_W), acc_en (acc += x*din), din = memory word, acc = running score.
module svm_mac
   import svm_ctrl_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ACC_W  = ACC_W_DEF,
   parameter int FRAC_W = FRAC_W_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     load,
   input  logic                     acc_en,
   input  logic signed [DATA_W-1:0] din,
   input  logic signed [DATA_W-1:0] x,
   output logic signed [ACC_W-1:0]  acc
);
   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W-1:0]    prod_ext;
   logic signed [ACC_W-1:0]    bias_ext;

   assign prod     = x * din;
   assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
   // Bias is moved into the product's Q-format before it seeds the accumulator.
   assign bias_ext = {{(ACC_W-DATA_W){din[DATA_W-1]}}, din} <<< FRAC_W;

   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= '0;
      end else if (load) begin
         acc <= bias_ext;
      end else if (acc_en) begin
         acc <= acc + prod_ext;
      end
   end
endmodule

// File: rtl/svm_ovr_ctrl.sv
// One-vs-rest linear SVM controller: reads x, per-class w and bias, scores each class, reports argmax.
// Latency: busy for n_class*(2*n_feat+3) cycles after start, then a one-cycle done pulse.
// Backpressure: start is ignored while busy; abort returns to idle next cycle with no done.
// Ports: start/abort/n_feat/n_class/bases in, mem read bus, busy/done/err/class_idx/max_score out.
module svm_ovr_ctrl
   import svm_ctrl_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int ACC_W     = ACC_W_DEF,
   parameter int FRAC_W    = FRAC_W_DEF,
   parameter int MAX_CLASS = MAX_CLASS_DEF,
   parameter int CLS_W     = $clog2(MAX_CLASS)
) (
   input  logic                    ACLK,
   input  logic                    ARESET,
   input  logic                    start,
   input  logic                    abort,
   input  logic [7:0]              n_feat,
   input  logic [CLS_W:0]          n_class,
   input  logic [ADDR_W-1:0]       x_base,
   input  logic [ADDR_W-1:0]       w_base,
   input  logic [ADDR_W-1:0]       b_base,
   svm_ovr_ctrl_if.master          mem,
   output logic                    busy,
   output logic                    done,
   output logic                    err,
   output logic [CLS_W-1:0]        class_idx,
   output logic signed [ACC_W-1:0] max_score
);
   localparam logic signed [ACC_W-1:0] MOST_NEG = {1'b1, {(ACC_W-1){1'b0}}};

   state_t                   state, state_nxt;
   logic [7:0]               n_feat_q, j;
   logic [CLS_W:0]           n_class_q;
   logic [CLS_W-1:0]         c, best_idx;
   logic [ADDR_W-1:0]        x_base_q, b_base_q, w_ptr;
   logic signed [DATA_W-1:0] x_q;
   logic signed [ACC_W-1:0]  acc, best;
   logic                     mac_load, mac_acc;
   logic                     rd_en_c;
   logic [ADDR_W-1:0]        rd_addr_c;
   logic                     start_ok, start_bad, last_feat, last_class, win;

   assign start_ok   = start && (n_feat != 8'd0) && (n_class != '0)
                       && (n_class <= (CLS_W+1)'(MAX_CLASS));
   assign start_bad  = start && !start_ok;
   assign last_feat  = (j == n_feat_q - 8'd1);
   assign last_class = ({1'b0, c} == n_class_q - (CLS_W+1)'(1));
   assign win        = (acc > best);
   assign busy       = (state != S_IDLE);
   assign mem.rd_en   = rd_en_c;
   assign mem.rd_addr = rd_addr_c;

   svm_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W), .FRAC_W(FRAC_W)) u_mac (
      .clk    (ACLK),
      .rst    (ARESET),
      .load   (mac_load),
      .acc_en (mac_acc),
      .din    (mem.rd_data),
      .x      (x_q),
      .acc    (acc)
   );

   always_comb begin
      state_nxt = state;
      mac_load  = 1'b0;
      mac_acc   = 1'b0;
      rd_en_c   = 1'b0;
      rd_addr_c = '0;
      case (state)
         S_IDLE:  if (start_ok) state_nxt = S_BIAS;
         S_BIAS: begin
            rd_en_c   = 1'b1;
            rd_addr_c = b_base_q + ADDR_W'(c);
            state_nxt = S_RD_X;
         end
         S_RD_X: begin
            rd_en_c   = 1'b1;
            rd_addr_c = x_base_q + ADDR_W'(j);
            // First RD_X of a class receives the bias; later ones receive the previous weight.
            if (j == 8'd0) mac_load = 1'b1;
            else           mac_acc  = 1'b1;
            state_nxt = S_RD_W;
         end
         S_RD_W: begin
            rd_en_c   = 1'b1;
            rd_addr_c = w_ptr;
            state_nxt = last_feat ? S_DRAIN : S_RD_X;
         end
         S_DRAIN: begin
            mac_acc   = 1'b1;
            state_nxt = S_CMP;
         end
         S_CMP:   state_nxt = last_class ? S_IDLE : S_BIAS;
         default: state_nxt = S_IDLE;
      endcase
      if (abort && state != S_IDLE) state_nxt = S_IDLE;
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state     <= S_IDLE;
         n_feat_q  <= '0;
         n_class_q <= '0;
         x_base_q  <= '0;
         b_base_q  <= '0;
         w_ptr     <= '0;
         j         <= '0;
         c         <= '0;
         x_q       <= '0;
         best      <= '0;
         best_idx  <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
         class_idx <= '0;
         max_score <= '0;
      end else begin
         state <= state_nxt;
         done  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start_bad) begin
                  err  <= 1'b1;
                  done <= 1'b1;
               end else if (start_ok) begin
                  err       <= 1'b0;
                  n_feat_q  <= n_feat;
                  n_class_q <= n_class;
                  x_base_q  <= x_base;
                  b_base_q  <= b_base;
                  w_ptr     <= w_base;
                  j         <= '0;
                  c         <= '0;
                  best      <= MOST_NEG;
                  best_idx  <= '0;
               end
            end
            S_RD_W: begin
               x_q   <= mem.rd_data;
               // Weights are stored class-major and contiguous, so one running pointer suffices.
               w_ptr <= w_ptr + ADDR_W'(1);
               if (!last_feat) j <= j + 8'd1;
            end
            S_CMP: begin
               if (win) begin
                  best     <= acc;
                  best_idx <= c;
               end
               if (!abort) begin
                  if (last_class) begin
                     done      <= 1'b1;
                     class_idx <= win ? c   : best_idx;
                     max_score <= win ? acc : best;
                  end else begin
                     c <= c + CLS_W'(1);
                     j <= '0;
                  end
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_svm_ovr_ctrl.sv
// Bench for svm_ovr_ctrl: memory responder, job-level score model, per-cycle compare, directed jobs.
// Latency: n/a.
// Backpressure: n/a.
module tb_svm_ovr_ctrl;
   import svm_ctrl_pkg::*;

   localparam int CW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst;
   logic                start, abort;
   logic [7:0]          n_feat;
   logic [CW:0]         n_class;
   logic [11:0]         x_base, w_base, b_base;
   logic                busy, done, err;
   logic [CW-1:0]       class_idx;
   logic signed [47:0]  max_score;

   svm_ovr_ctrl_if mem_if();

   svm_ovr_ctrl dut (
      .ACLK(clk), .ARESET(rst), .start(start), .abort(abort),
      .n_feat(n_feat), .n_class(n_class),
      .x_base(x_base), .w_base(w_base), .b_base(b_base),
      .mem(mem_if), .busy(busy), .done(done), .err(err),
      .class_idx(class_idx), .max_score(max_score)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Memory: answers the read issued in the previous cycle, junk otherwise.
   logic signed [15:0] mem [0:4095];
   logic               pend_en = 1'b0;
   logic [11:0]        pend_addr = '0;
   always @(negedge clk) begin
      mem_if.rd_data = pend_en ? mem[pend_addr] : 16'sh5A5A;
      pend_en   = mem_if.rd_en;
      pend_addr = mem_if.rd_addr;
   end

   // Job-level model: scores every class directly from memory contents at start.
   function automatic void score_job(input int nf, input int nc, input int xb, input int wb,
                                     input int bb, output int bi, output longint bs);
      longint s;
      bi = 0;
      bs = 0;
      for (int cc = 0; cc < nc; cc++) begin
         s = longint'(mem[bb + cc]) * 256;
         for (int jj = 0; jj < nf; jj++)
            s += longint'(mem[xb + jj]) * longint'(mem[wb + cc * nf + jj]);
         if (cc == 0 || s > bs) begin
            bi = cc;
            bs = s;
         end
      end
   endfunction

   int                 m_left = 0;
   logic               m_done = 1'b0, m_err = 1'b0;
   logic [CW-1:0]      m_idx = '0;
   logic signed [47:0] m_score = '0;
   int                 p_idx = 0;
   longint             p_score = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_left = 0; m_done = 1'b0; m_err = 1'b0; m_idx = '0; m_score = '0;
      end else if (m_left > 0) begin
         m_done = 1'b0;
         if (abort) m_left = 0;
         else begin
            m_left--;
            if (m_left == 0) begin
               m_done  = 1'b1;
               m_idx   = p_idx[CW-1:0];
               m_score = p_score[47:0];
            end
         end
      end else begin
         m_done = 1'b0;
         if (start) begin
            if (n_feat == 0 || n_class == 0 || n_class > 16) begin
               m_err  = 1'b1;
               m_done = 1'b1;
            end else begin
               m_err  = 1'b0;
               m_left = int'(n_class) * (2 * int'(n_feat) + 3);
               score_job(int'(n_feat), int'(n_class), int'(x_base), int'(w_base), int'(b_base),
                         p_idx, p_score);
            end
         end
      end
   end

   int bcnt = 0;
   always @(posedge clk) if (busy === 1'b1) bcnt++;

   logic cmp_en = 1'b0;
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("busy", busy, m_left > 0);
         chk("done", done, m_done);
         chk("err", err, m_err);
         chk("class_idx", class_idx, m_idx);
         chk("max_score", max_score, m_score);
         chk("rd_en_outside_job", mem_if.rd_en && (m_left == 0), 0);
         if (!mem_if.rd_en) chk("rd_addr_idle", mem_if.rd_addr, 0);
      end
   end

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic start_job(input int nf, input int nc, input int xb, input int wb, input int bb);
      n_feat = 8'(nf); n_class = 5'(nc);
      x_base = 12'(xb); w_base = 12'(wb); b_base = 12'(bb);
      bcnt   = 0;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
   endtask

   task automatic wait_done(input string nm);
      bit got = 0;
      for (int k = 0; k < 2000 && !got; k++) begin
         if (done === 1'b1) got = 1;
         else @(negedge clk);
      end
      chk({nm, "_done_seen"}, got, 1);
   endtask

   task automatic job(input string nm, input int nf, input int nc, input int xb, input int wb,
                      input int bb, input int e_idx, input longint e_score, input int e_cyc);
      start_job(nf, nc, xb, wb, bb);
      wait_done(nm);
      chk({nm, "_idx"}, class_idx, e_idx);
      chk({nm, "_score"}, max_score, e_score);
      chk({nm, "_busy_cycles"}, bcnt, e_cyc);
   endtask

   task automatic bad_start(input string nm, input int nf, input int nc);
      start_job(nf, nc, 16, 256, 512);
      chk({nm, "_err"}, err, 1);
      chk({nm, "_done"}, done, 1);
      chk({nm, "_busy"}, busy, 0);
      @(negedge clk);
      chk({nm, "_done_pulse"}, done, 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      n_feat = '0; n_class = '0; x_base = '0; w_base = '0; b_base = '0;
      for (int a = 0; a < 4096; a++) mem[a] = '0;
      // Main job: x@0x010, w@0x100, b@0x200
      mem[16] = 1; mem[17] = 2; mem[18] = 3; mem[19] = 4;
      mem[256] = 1; mem[257] = 0; mem[258] = 0; mem[259] = 0;
      mem[260] = 0; mem[261] = 0; mem[262] = 0; mem[263] = 1;
      mem[264] = 1; mem[265] = 1; mem[266] = 1; mem[267] = 1;
      // Bias only: x@0x020, w@0x110, b@0x210
      mem[32] = 0; mem[272] = 7; mem[273] = -3; mem[528] = -1; mem[529] = 5;
      // Tie: x@0x030, w@0x120, b@0x220
      mem[48] = 3; mem[49] = -2;
      mem[288] = 5; mem[289] = 4; mem[290] = 5; mem[291] = 4;
      mem[544] = 2; mem[545] = 2;
      // All negative: x@0x040, w@0x130, b@0x230
      mem[64] = 1; mem[304] = -7; mem[305] = -3; mem[560] = 0; mem[561] = 0;

      repeat (2) @(negedge clk);
      cmp_en = 1'b1;
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_err", err, 0);
      chk("reset_rd_en", mem_if.rd_en, 0);
      chk("reset_score", max_score, 0);
      rst = 1'b0;
      @(negedge clk);

      job("main",  4, 3, 16, 256, 512, 2, 10, 33);
      job("bias",  1, 2, 32, 272, 528, 1, 1280, 10);
      job("tie",   2, 2, 48, 288, 544, 0, 519, 14);
      job("neg",   1, 2, 64, 304, 560, 1, -3, 10);

      bad_start("nclass0", 4, 0);
      bad_start("nclass17", 4, 17);
      bad_start("nfeat0", 0, 2);
      chk("err_keeps_idx", class_idx, 1);
      chk("err_keeps_score", max_score, -3);

      // Abort while in RD_W of class 1 (14th busy cycle).
      start_job(4, 3, 16, 256, 512);
      repeat (13) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_idx", class_idx, 1);
      chk("abort_score", max_score, -3);
      job("after_abort", 4, 3, 16, 256, 512, 2, 10, 33);

      // A start during a job must not disturb it.
      start_job(1, 2, 32, 272, 528);
      repeat (3) @(negedge clk);
      n_feat = 8'd4; n_class = 5'd3; x_base = 12'd16; w_base = 12'd256; b_base = 12'd512;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("ignored_start");
      chk("ignored_start_idx", class_idx, 1);
      chk("ignored_start_score", max_score, 1280);
      chk("ignored_start_cycles", bcnt, 10);

      // Reset in the middle of a job.
      start_job(4, 3, 16, 256, 512);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_busy", busy, 0);
      chk("midrst_rd_en", mem_if.rd_en, 0);
      chk("midrst_idx", class_idx, 0);
      chk("midrst_score", max_score, 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("post_rst_done", done, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
